// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ packet sources.
// A grant is held for a whole packet, capped at BURST_MAX beats.
module fifo_wr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 64,
    parameter int unsigned BURST_MAX = 16,
    parameter int unsigned WCNT_W    = 8,
    parameter int unsigned DEPTH_W   = 256,
    parameter int unsigned MIN_FREE  = 1,
    localparam int unsigned IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    output logic               fifo_w_req,
    output logic [DW-1:0]      fifo_data,
    input  logic               fifo_full,
    input  logic [WCNT_W-1:0]  fifo_w_cnt,
    output logic               busy,
    output logic [IDW-1:0]     grant_id
);

    localparam int unsigned BCW = $clog2(BURST_MAX + 1);
    localparam logic [WCNT_W:0] DepthWords = (WCNT_W + 1)'(DEPTH_W);
    localparam logic [WCNT_W:0] MinFree    = (WCNT_W + 1)'(MIN_FREE);
    localparam logic [BCW-1:0]  LastBeat   = BCW'(BURST_MAX - 1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state_q;
    logic [IDW-1:0]  grant_id_q;
    logic [BCW-1:0]  beat_cnt_q;

    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  cand;
    logic            found;
    logic [WCNT_W:0] free_words;
    logic            admit;
    logic            sel_valid;
    logic            sel_last;

    // Search starts just past the previous grantee so every source gets a turn.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(grant_id_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign free_words = DepthWords - {1'b0, fifo_w_cnt};
    assign admit      = found && (free_words >= MinFree);
    assign sel_valid  = req_valid[grant_id_q];
    assign sel_last   = req_last[grant_id_q];

    always_comb begin
        fifo_data = '0;
        req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_id_q == IDW'(i)) begin
                fifo_data    = req_data[i*DW +: DW];
                req_ready[i] = (state_q == StBusy) && !fifo_full;
            end
        end
    end

    assign fifo_w_req = (state_q == StBusy) && sel_valid && !fifo_full;
    assign busy       = (state_q == StBusy);
    assign grant_id   = grant_id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            grant_id_q <= IDW'(NREQ - 1);
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (admit) begin
                        grant_id_q <= winner;
                        beat_cnt_q <= '0;
                        state_q    <= StBusy;
                    end
                end
                StBusy: begin
                    // Release only on packet end or burst cap; a stalled source keeps the grant.
                    if (fifo_w_req) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (sel_last || beat_cnt_q == LastBeat) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: source models drive packets and the
// per-cycle write-port trace is compared with hand-written expected traces.
module tb_fifo_wr_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              fifo_w_req;
    logic [DW-1:0]     fifo_data;
    logic              fifo_full;
    logic [7:0]        fifo_w_cnt;
    logic              busy;
    logic [1:0]        grant_id;

    fifo_wr_arbiter #(
        .NREQ     (NREQ),
        .DW       (DW),
        .BURST_MAX(16),
        .WCNT_W   (8),
        .DEPTH_W  (256),
        .MIN_FREE (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .fifo_w_req(fifo_w_req),
        .fifo_data (fifo_data),
        .fifo_full (fifo_full),
        .fifo_w_cnt(fifo_w_cnt),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Source model state: beats remaining, beats sent, position in packet, packet length.
    int rem [NREQ];
    int sent[NREQ];
    int pos [NREQ];
    int plen[NREQ];

    // Trace entry: {ready[3:0], busy, w_req, grant_id[1:0], data-if-written[15:0]}
    logic [23:0] trace[$];
    logic [23:0] expq[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [23:0] wr(input int r, input int b);
        return {4'(1 << r), 1'b1, 1'b1, 2'(r), 4'(r), 12'(b)};
    endfunction

    function automatic logic [23:0] idl(input int g);
        return {4'b0, 1'b0, 1'b0, 2'(g), 16'h0};
    endfunction

    function automatic logic [23:0] stl(input int g);
        return {4'b0, 1'b1, 1'b0, 2'(g), 16'h0};
    endfunction

    task automatic load(input int r, input int n, input int len);
        rem[r]  = n;
        plen[r] = len;
        pos[r]  = 0;
        sent[r] = 0;
    endtask

    task automatic step();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = (rem[i] != 0);
            req_last[i]           = (rem[i] == 1) || (pos[i] == plen[i] - 1);
            req_data[i*DW +: DW]  = {4'(i), 12'(sent[i])};
        end
        #1;
        trace.push_back({req_ready, busy, fifo_w_req, grant_id, fifo_w_req ? fifo_data : 16'h0});
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                rem[i]--;
                sent[i]++;
                pos[i] = req_last[i] ? 0 : pos[i] + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic compare_trace(input string name);
        int n;
        check_eq({name, "_len"}, 32'(trace.size()), 32'(expq.size()));
        n = (trace.size() < expq.size()) ? trace.size() : expq.size();
        for (int k = 0; k < n; k++) begin
            check_eq($sformatf("%s[%0d]", name, k), 32'(trace[k]), 32'(expq[k]));
        end
        trace.delete();
        expq.delete();
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_last   = '0;
        req_data   = '0;
        fifo_full  = 1'b0;
        fifo_w_cnt = '0;
        for (int i = 0; i < NREQ; i++) load(i, 0, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_grant_id", 32'(grant_id), 32'd3);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_w_req", 32'(fifo_w_req), 32'd0);
        rst = 1'b0;

        // Two 1-beat packets per source: round robin from 0 with an idle bubble between grants.
        for (int i = 0; i < NREQ; i++) load(i, 2, 1);
        run(17);
        expq.push_back(idl(3));
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 4; r++) begin
                expq.push_back(wr(r, b));
                expq.push_back(idl(r));
            end
        end
        compare_trace("rr_first");

        // Requester 2 holds the grant for its 5-beat packet while 0 waits.
        load(2, 5, 5);
        run(1);
        load(0, 1, 1);
        run(8);
        expq.push_back(idl(3));
        for (int b = 0; b < 5; b++) expq.push_back(wr(2, b));
        expq.push_back(idl(2));
        expq.push_back(wr(0, 0));
        expq.push_back(idl(0));
        compare_trace("hold");

        // 20-beat packet is split at 16 beats; requester 3 slips in between fragments.
        load(1, 20, 20);
        load(3, 2, 2);
        run(26);
        expq.push_back(idl(0));
        for (int b = 0; b < 16; b++) expq.push_back(wr(1, b));
        expq.push_back(idl(1));
        expq.push_back(wr(3, 0));
        expq.push_back(wr(3, 1));
        expq.push_back(idl(3));
        for (int b = 16; b < 20; b++) expq.push_back(wr(1, b));
        expq.push_back(idl(1));
        compare_trace("split");

        // Full for 3 cycles mid-packet; the burst cap must still land after exactly 16 writes.
        load(2, 18, 18);
        run(3);
        fifo_full = 1'b1;
        run(3);
        fifo_full = 1'b0;
        run(18);
        expq.push_back(idl(1));
        expq.push_back(wr(2, 0));
        expq.push_back(wr(2, 1));
        for (int k = 0; k < 3; k++) expq.push_back(stl(2));
        for (int b = 2; b < 16; b++) expq.push_back(wr(2, b));
        expq.push_back(idl(2));
        expq.push_back(wr(2, 16));
        expq.push_back(wr(2, 17));
        expq.push_back(idl(2));
        compare_trace("backpressure");

        // Admission gate: 8 free words needed (256 - 248).
        load(0, 1, 1);
        fifo_w_cnt = 8'd250;
        run(2);
        fifo_w_cnt = 8'd249;
        run(2);
        fifo_w_cnt = 8'd248;
        run(3);
        fifo_w_cnt = 8'd0;
        for (int k = 0; k < 5; k++) expq.push_back(idl(2));
        expq.push_back(wr(0, 0));
        expq.push_back(idl(0));
        compare_trace("admission");

        // Reset during beat 3 of a 6-beat packet: grant dropped, pointer back to NREQ-1.
        load(1, 6, 6);
        run(3);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        load(0, 1, 1);
        run(7);
        expq.push_back(idl(0));
        for (int b = 0; b < 3; b++) expq.push_back(wr(1, b));
        expq.push_back(idl(3));
        expq.push_back(wr(0, 0));
        expq.push_back(idl(0));
        for (int b = 3; b < 6; b++) expq.push_back(wr(1, b));
        expq.push_back(idl(1));
        compare_trace("mid_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
